// File: rtl/noc_endpoint_if.sv
`default_nettype none
//==============================================================================
// Module   : noc_endpoint_if
// Brief    : Client TX/RX handshakes and CONNECT send/receive port signals
//            bundled for noc_endpoint; slave = endpoint, master = surroundings.
// Revision : 1.0
//==============================================================================
interface noc_endpoint_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int VC_W   = 2
);
    localparam int FLIT_W = 2 + DEST_W + VC_W + DATA_W;

    // Client transmit side
    logic              tx_valid;
    logic              tx_ready;
    logic [DEST_W-1:0] tx_dest;
    logic [VC_W-1:0]   tx_vc;
    logic              tx_tail;
    logic [DATA_W-1:0] tx_data;

    // Network send port
    logic [FLIT_W-1:0] putFlit;
    logic              EN_putFlit;
    logic [VC_W:0]     getCredits;

    // Network receive port
    logic [FLIT_W-1:0] getFlit;
    logic              EN_getFlit;
    logic [VC_W:0]     putCredits;
    logic              EN_putCredits;

    // Client receive side
    logic              rx_valid;
    logic              rx_ready;
    logic [DEST_W-1:0] rx_dest;
    logic [VC_W-1:0]   rx_vc;
    logic              rx_tail;
    logic [DATA_W-1:0] rx_data;

    logic              err;

    modport slave (
        input  tx_valid, tx_dest, tx_vc, tx_tail, tx_data,
        output tx_ready,
        output putFlit, EN_putFlit,
        input  getCredits,
        input  getFlit,
        output EN_getFlit, putCredits, EN_putCredits,
        output rx_valid, rx_dest, rx_vc, rx_tail, rx_data,
        input  rx_ready,
        output err
    );

    modport master (
        output tx_valid, tx_dest, tx_vc, tx_tail, tx_data,
        input  tx_ready,
        input  putFlit, EN_putFlit,
        output getCredits,
        output getFlit,
        input  EN_getFlit, putCredits, EN_putCredits,
        input  rx_valid, rx_dest, rx_vc, rx_tail, rx_data,
        output rx_ready,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/noc_endpoint.sv
`default_nettype none
//==============================================================================
// Module   : noc_endpoint
// Brief    : Credit-managed CONNECT endpoint: TX queue with per-VC credit
//            gating, RX queue with per-flit credit return. Define
//            NOC_EP_STATS_EN to add tx_count/rx_count/stall_count outputs.
// Revision : 1.0
//==============================================================================
module noc_endpoint #(
    parameter int DATA_W    = 32,
    parameter int DEST_W    = 5,
    parameter int VC_W      = 2,
    parameter int NUM_VC    = 1,
    parameter int CREDITS   = 16,
    parameter int TXQ_DEPTH = 4,
    parameter int RXQ_DEPTH = 4
)(
    input  wire logic          sys_clk,
    input  wire logic          nreset,
    noc_endpoint_if.slave      bus
`ifdef NOC_EP_STATS_EN
    ,
    output logic [31:0]        tx_count,
    output logic [31:0]        rx_count,
    output logic [31:0]        stall_count
`endif
);
    localparam int c_ent_w  = 1 + DEST_W + VC_W + DATA_W;   // {tail, dest, vc, data}
    localparam int c_flit_w = 1 + c_ent_w;
    localparam int c_cred_w = $clog2(CREDITS + 1);
    localparam int c_txa_w  = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
    localparam int c_txc_w  = $clog2(TXQ_DEPTH + 1);
    localparam int c_rxa_w  = (RXQ_DEPTH > 1) ? $clog2(RXQ_DEPTH) : 1;
    localparam int c_rxc_w  = $clog2(RXQ_DEPTH + 1);
    localparam logic [c_cred_w-1:0] c_credits_init = c_cred_w'(CREDITS);

    //--------------------------------------------------------------------------
    // Transmit queue and inject decision
    //--------------------------------------------------------------------------
    logic [c_ent_w-1:0]  r_txq [TXQ_DEPTH];
    logic [c_txa_w-1:0]  r_tx_wr;
    logic [c_txa_w-1:0]  r_tx_rd;
    logic [c_txc_w-1:0]  r_tx_cnt;
    logic [c_cred_w-1:0] r_credit [NUM_VC];
    logic [c_flit_w-1:0] r_put_flit;
    logic                r_en_put_flit;

    logic                w_tx_empty;
    logic                w_tx_full;
    logic                w_tx_push;
    logic [c_ent_w-1:0]  w_tx_in;
    logic [c_ent_w-1:0]  w_cand;
    logic                w_cand_valid;
    logic [VC_W-1:0]     w_cand_vc;
    logic [c_cred_w-1:0] w_head_credit;
    logic                w_inject;
    logic                w_bypass;
    logic                w_tx_pop;
    logic                w_tx_wr_en;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == c_txc_w'(TXQ_DEPTH));
    assign w_tx_push  = bus.tx_valid && !w_tx_full;
    assign w_tx_in    = {bus.tx_tail, bus.tx_dest, bus.tx_vc, bus.tx_data};

    // An empty queue lets the arriving flit compete directly, so a push in
    // cycle N can be on the wire in N+1.
    assign w_cand       = w_tx_empty ? w_tx_in : r_txq[r_tx_rd];
    assign w_cand_valid = !w_tx_empty || w_tx_push;
    assign w_cand_vc    = w_cand[DATA_W +: VC_W];

    always_comb begin
        w_head_credit = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_cand_vc == VC_W'(v)) begin
                w_head_credit = r_credit[v];
            end
        end
    end

    assign w_inject   = w_cand_valid && (w_head_credit != '0);
    assign w_bypass   = w_tx_empty && w_inject;
    assign w_tx_pop   = !w_tx_empty && w_inject;
    assign w_tx_wr_en = w_tx_push && !w_bypass;

    always_ff @(posedge sys_clk) begin
        if (w_tx_wr_en) begin
            r_txq[r_tx_wr] <= w_tx_in;
        end
    end

    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            r_tx_wr       <= '0;
            r_tx_rd       <= '0;
            r_tx_cnt      <= '0;
            r_put_flit    <= '0;
            r_en_put_flit <= 1'b0;
        end else begin
            if (w_tx_wr_en) begin
                r_tx_wr <= (r_tx_wr == c_txa_w'(TXQ_DEPTH - 1)) ? '0 : r_tx_wr + c_txa_w'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd <= (r_tx_rd == c_txa_w'(TXQ_DEPTH - 1)) ? '0 : r_tx_rd + c_txa_w'(1);
            end
            r_tx_cnt      <= r_tx_cnt + c_txc_w'(w_tx_wr_en) - c_txc_w'(w_tx_pop);
            r_en_put_flit <= w_inject;
            r_put_flit    <= w_inject ? {1'b1, w_cand} : '0;
        end
    end

    //--------------------------------------------------------------------------
    // Per-VC credit counters
    //--------------------------------------------------------------------------
    logic                w_cr_valid;
    logic [VC_W-1:0]     w_cr_vc;
    logic [NUM_VC-1:0]   w_cr_inc;
    logic [NUM_VC-1:0]   w_cr_dec;
    logic [NUM_VC-1:0]   w_cr_ovf;

    assign w_cr_valid = bus.getCredits[VC_W];
    assign w_cr_vc    = bus.getCredits[VC_W-1:0];

    // A return and a send on the same VC cancel, so only an unmatched
    // return at the full count is an overflow.
    always_comb begin
        w_cr_inc = '0;
        w_cr_dec = '0;
        w_cr_ovf = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_cr_inc[v] = w_cr_valid && (w_cr_vc == VC_W'(v));
            w_cr_dec[v] = w_inject && (w_cand_vc == VC_W'(v));
            w_cr_ovf[v] = w_cr_inc[v] && !w_cr_dec[v] && (r_credit[v] == c_credits_init);
        end
    end

    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_credit[v] <= c_credits_init;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_cr_inc[v] && !w_cr_dec[v] && !w_cr_ovf[v]) begin
                    r_credit[v] <= r_credit[v] + c_cred_w'(1);
                end else if (w_cr_dec[v] && !w_cr_inc[v]) begin
                    r_credit[v] <= r_credit[v] - c_cred_w'(1);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Receive queue and credit return
    //--------------------------------------------------------------------------
    logic [c_ent_w-1:0]  r_rxq [RXQ_DEPTH];
    logic [c_rxa_w-1:0]  r_rx_wr;
    logic [c_rxa_w-1:0]  r_rx_rd;
    logic [c_rxc_w-1:0]  r_rx_cnt;
    logic [VC_W:0]       r_put_credits;
    logic                r_en_put_credits;
    logic                r_err;

    logic                w_rx_empty;
    logic                w_rx_full;
    logic                w_rx_in_valid;
    logic                w_rx_pop;
    logic                w_rx_push;
    logic                w_rx_drop;
    logic [c_ent_w-1:0]  w_rx_head;

    assign w_rx_empty    = (r_rx_cnt == '0);
    assign w_rx_full     = (r_rx_cnt == c_rxc_w'(RXQ_DEPTH));
    assign w_rx_in_valid = bus.getFlit[c_flit_w-1];
    assign w_rx_head     = r_rxq[r_rx_rd];
    assign w_rx_pop      = !w_rx_empty && bus.rx_ready;
    // A flit arriving at full still fits when the client frees a slot in
    // the same cycle; otherwise it is lost.
    assign w_rx_push     = w_rx_in_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_drop     = w_rx_in_valid && w_rx_full && !w_rx_pop;

    always_ff @(posedge sys_clk) begin
        if (w_rx_push) begin
            r_rxq[r_rx_wr] <= bus.getFlit[c_ent_w-1:0];
        end
    end

    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            r_rx_wr          <= '0;
            r_rx_rd          <= '0;
            r_rx_cnt         <= '0;
            r_put_credits    <= '0;
            r_en_put_credits <= 1'b0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr <= (r_rx_wr == c_rxa_w'(RXQ_DEPTH - 1)) ? '0 : r_rx_wr + c_rxa_w'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd <= (r_rx_rd == c_rxa_w'(RXQ_DEPTH - 1)) ? '0 : r_rx_rd + c_rxa_w'(1);
            end
            r_rx_cnt         <= r_rx_cnt + c_rxc_w'(w_rx_push) - c_rxc_w'(w_rx_pop);
            r_en_put_credits <= w_rx_pop;
            r_put_credits    <= w_rx_pop ? {1'b1, w_rx_head[DATA_W +: VC_W]} : '0;
        end
    end

    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            r_err <= 1'b0;
        end else if ((|w_cr_ovf) || w_rx_drop) begin
            r_err <= 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.tx_ready      = !w_tx_full;
    assign bus.putFlit       = r_put_flit;
    assign bus.EN_putFlit    = r_en_put_flit;
    assign bus.EN_getFlit    = !w_rx_full;
    assign bus.putCredits    = r_put_credits;
    assign bus.EN_putCredits = r_en_put_credits;
    assign bus.rx_valid      = !w_rx_empty;
    assign bus.rx_tail       = w_rx_head[c_ent_w-1];
    assign bus.rx_dest       = w_rx_head[DATA_W + VC_W +: DEST_W];
    assign bus.rx_vc         = w_rx_head[DATA_W +: VC_W];
    assign bus.rx_data       = w_rx_head[DATA_W-1:0];
    assign bus.err           = r_err;

`ifdef NOC_EP_STATS_EN
    logic [31:0] r_tx_count;
    logic [31:0] r_rx_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            r_tx_count    <= '0;
            r_rx_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_inject) begin
                r_tx_count <= r_tx_count + 32'd1;
            end
            if (w_rx_push) begin
                r_rx_count <= r_rx_count + 32'd1;
            end
            if (!w_tx_empty && (w_head_credit == '0)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign tx_count    = r_tx_count;
    assign rx_count    = r_rx_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_endpoint.sv
`default_nettype none
//==============================================================================
// Module   : tb_noc_endpoint
// Brief    : Scoreboard bench for noc_endpoint (2 VCs, 16 credits, depth 4).
// Revision : 1.0
//==============================================================================
module tb_noc_endpoint;
    localparam int DATA_W  = 32;
    localparam int DEST_W  = 5;
    localparam int VC_W    = 2;
    localparam int NUM_VC  = 2;
    localparam int CREDITS = 16;
    localparam int FLIT_W  = 2 + DEST_W + VC_W + DATA_W;

    logic clk    = 1'b0;
    logic nreset = 1'b1;
    always #5 clk = ~clk;

    noc_endpoint_if #(.DATA_W(DATA_W), .DEST_W(DEST_W), .VC_W(VC_W)) bus ();

`ifdef NOC_EP_STATS_EN
    logic [31:0] tx_count, rx_count, stall_count;
`endif

    noc_endpoint #(
        .DATA_W(DATA_W), .DEST_W(DEST_W), .VC_W(VC_W), .NUM_VC(NUM_VC),
        .CREDITS(CREDITS), .TXQ_DEPTH(4), .RXQ_DEPTH(4)
    ) dut (
        .sys_clk (clk),
        .nreset  (nreset),
        .bus     (bus.slave)
`ifdef NOC_EP_STATS_EN
        ,
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .stall_count (stall_count)
`endif
    );

    typedef struct { logic [FLIT_W-1:0] flit; int c; } tx_obs_t;
    typedef struct { logic [VC_W:0]     cr;   int c; } cr_obs_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [FLIT_W-1:0] exp_tx[$];
    tx_obs_t           obs_tx[$];
    logic [FLIT_W-1:0] exp_rx[$];
    cr_obs_t           exp_cr[$];
    cr_obs_t           obs_cr[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records every strobe from the network-facing outputs with its cycle.
    always @(posedge clk) begin
        #1;
        if (bus.EN_putFlit)    obs_tx.push_back('{bus.putFlit, cyc});
        if (bus.EN_putCredits) obs_cr.push_back('{bus.putCredits, cyc});
    end

    function automatic logic [FLIT_W-1:0] mk_flit(input logic tail, input logic [DEST_W-1:0] dest,
                                                  input logic [VC_W-1:0] vc, input logic [DATA_W-1:0] data);
        return {1'b1, tail, dest, vc, data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tx_valid   = 1'b0;
        bus.tx_dest    = '0;
        bus.tx_vc      = '0;
        bus.tx_tail    = 1'b0;
        bus.tx_data    = '0;
        bus.getCredits = '0;
        bus.getFlit    = '0;
        bus.rx_ready   = 1'b0;
    endtask

    task automatic drive_tx(input logic tail, input logic [DEST_W-1:0] dest,
                            input logic [VC_W-1:0] vc, input logic [DATA_W-1:0] data);
        bus.tx_valid = 1'b1;
        bus.tx_tail  = tail;
        bus.tx_dest  = dest;
        bus.tx_vc    = vc;
        bus.tx_data  = data;
    endtask

    task automatic do_reset();
        step();
        nreset = 1'b0;
        idle_inputs();
        repeat (2) step();
        nreset = 1'b1;
        step();
        exp_tx.delete(); obs_tx.delete(); exp_rx.delete(); exp_cr.delete(); obs_cr.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 nreset = 1'b0;
        repeat (2) step();
        n_cmp++; if (bus.tx_ready !== 1'b1)      begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready); end
        n_cmp++; if (bus.EN_putFlit !== 1'b0)    begin n_bad++; $display("FAIL reset_en_putflit: got %b want 0", bus.EN_putFlit); end
        n_cmp++; if (bus.putFlit !== '0)         begin n_bad++; $display("FAIL reset_putflit: got %h want 0", bus.putFlit); end
        n_cmp++; if (bus.EN_putCredits !== 1'b0) begin n_bad++; $display("FAIL reset_en_putcredits: got %b want 0", bus.EN_putCredits); end
        n_cmp++; if (bus.putCredits !== '0)      begin n_bad++; $display("FAIL reset_putcredits: got %b want 0", bus.putCredits); end
        n_cmp++; if (bus.rx_valid !== 1'b0)      begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        n_cmp++; if (bus.EN_getFlit !== 1'b1)    begin n_bad++; $display("FAIL reset_en_getflit: got %b want 1", bus.EN_getFlit); end
        n_cmp++; if (bus.err !== 1'b0)           begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        nreset = 1'b1;
        step();
    endtask

    task automatic test_packet();
        int c0;
        do_reset();
        c0 = cyc;
        drive_tx(1'b0, 5'd1, 2'd0, 32'hA);
        exp_tx.push_back(mk_flit(1'b0, 5'd1, 2'd0, 32'hA));
        step();
        drive_tx(1'b1, 5'd1, 2'd0, 32'hB);
        exp_tx.push_back(mk_flit(1'b1, 5'd1, 2'd0, 32'hB));
        step();
        idle_inputs();
        repeat (2) step();
        n_cmp++;
        if (obs_tx.size() != 2) begin
            n_bad++; $display("FAIL pkt_count: got %0d flits want 2", obs_tx.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++; if (obs_tx[i].flit !== exp_tx[i]) begin n_bad++; $display("FAIL pkt_flit%0d: got %h want %h", i, obs_tx[i].flit, exp_tx[i]); end
                n_cmp++; if (obs_tx[i].c != c0 + 1 + i)   begin n_bad++; $display("FAIL pkt_cycle%0d: got %0d want %0d", i, obs_tx[i].c, c0 + 1 + i); end
            end
        end
        n_cmp++; if (dut.r_credit[0] !== 5'd14) begin n_bad++; $display("FAIL pkt_credit0: got %0d want 14", dut.r_credit[0]); end
        n_cmp++; if (bus.EN_putFlit !== 1'b0)   begin n_bad++; $display("FAIL pkt_idle: got %b want 0", bus.EN_putFlit); end
    endtask

    task automatic test_credit_stall();
        int c1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            int  w   = 0;
            bit  acc = 1'b0;
            drive_tx(i == 17, 5'd2, 2'd0, 32'h100 + i);
            while (!acc && w < 20) begin
                acc = bus.tx_ready;
                if (acc) exp_tx.push_back(mk_flit(i == 17, 5'd2, 2'd0, 32'h100 + i));
                step();
                w++;
            end
            if (!acc) begin n_cmp++; n_bad++; $display("FAIL stall_push_timeout: flit %0d not accepted", i); end
        end
        idle_inputs();
        repeat (3) step();
        n_cmp++; if (obs_tx.size() != 16)       begin n_bad++; $display("FAIL stall_injected: got %0d want 16", obs_tx.size()); end
        n_cmp++; if (dut.r_credit[0] !== 5'd0)  begin n_bad++; $display("FAIL stall_credit0: got %0d want 0", dut.r_credit[0]); end
        if (obs_tx.size() >= 16) begin
            n_cmp++; if (obs_tx[15].c - obs_tx[0].c != 15) begin n_bad++; $display("FAIL stall_rate: got span %0d want 15", obs_tx[15].c - obs_tx[0].c); end
        end
        c1 = cyc;
        bus.getCredits = {1'b1, 2'd0};
        step();
        bus.getCredits = '0;
        repeat (4) step();
        n_cmp++;
        if (obs_tx.size() != 17) begin
            n_bad++; $display("FAIL stall_release_count: got %0d want 17", obs_tx.size());
        end else begin
            n_cmp++; if (obs_tx[16].c != c1 + 2) begin n_bad++; $display("FAIL stall_release_cycle: got %0d want %0d", obs_tx[16].c, c1 + 2); end
            for (int i = 0; i < 17; i++) begin
                n_cmp++; if (obs_tx[i].flit !== exp_tx[i]) begin n_bad++; $display("FAIL stall_flit%0d: got %h want %h", i, obs_tx[i].flit, exp_tx[i]); end
            end
        end
    endtask

    task automatic test_credit_edge();
        do_reset();
        drive_tx(1'b1, 5'd3, 2'd1, 32'h55);
        exp_tx.push_back(mk_flit(1'b1, 5'd3, 2'd1, 32'h55));
        bus.getCredits = {1'b1, 2'd1};
        step();
        idle_inputs();
        repeat (2) step();
        n_cmp++;
        if (obs_tx.size() != 1) begin
            n_bad++; $display("FAIL edge_count: got %0d want 1", obs_tx.size());
        end else begin
            n_cmp++; if (obs_tx[0].flit !== exp_tx[0]) begin n_bad++; $display("FAIL edge_flit: got %h want %h", obs_tx[0].flit, exp_tx[0]); end
        end
        n_cmp++; if (dut.r_credit[1] !== 5'd16) begin n_bad++; $display("FAIL edge_same_cycle_credit1: got %0d want 16", dut.r_credit[1]); end
        n_cmp++; if (bus.err !== 1'b0)          begin n_bad++; $display("FAIL edge_no_err: got %b want 0", bus.err); end
        bus.getCredits = {1'b1, 2'd0};
        step();
        bus.getCredits = '0;
        step();
        n_cmp++; if (bus.err !== 1'b1)          begin n_bad++; $display("FAIL edge_ovf_err: got %b want 1", bus.err); end
        n_cmp++; if (dut.r_credit[0] !== 5'd16) begin n_bad++; $display("FAIL edge_ovf_credit0: got %0d want 16", dut.r_credit[0]); end
    endtask

    task automatic test_rx_overrun();
        logic [VC_W-1:0] vcs [4];
        logic [FLIT_W-1:0] got;
        vcs = '{2'd1, 2'd0, 2'd1, 2'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.EN_getFlit !== 1'b1) begin n_bad++; $display("FAIL rx_en_before%0d: got %b want 1", i, bus.EN_getFlit); end
            bus.getFlit = mk_flit(i == 3, DEST_W'(i + 4), vcs[i], 32'h200 + i);
            exp_rx.push_back(mk_flit(i == 3, DEST_W'(i + 4), vcs[i], 32'h200 + i));
            step();
        end
        bus.getFlit = '0;
        n_cmp++; if (bus.EN_getFlit !== 1'b0) begin n_bad++; $display("FAIL rx_en_full: got %b want 0", bus.EN_getFlit); end
        n_cmp++; if (bus.rx_valid !== 1'b1)   begin n_bad++; $display("FAIL rx_valid_full: got %b want 1", bus.rx_valid); end
        n_cmp++; if (bus.err !== 1'b0)        begin n_bad++; $display("FAIL rx_err_before: got %b want 0", bus.err); end
        bus.getFlit = mk_flit(1'b1, 5'd31, 2'd3, 32'hDEAD);
        step();
        bus.getFlit = '0;
        step();
        n_cmp++; if (bus.err !== 1'b1)        begin n_bad++; $display("FAIL rx_overrun_err: got %b want 1", bus.err); end
        bus.rx_ready = 1'b1;
        for (int w = 0; w < 12; w++) begin
            if (bus.rx_valid) begin
                got = {1'b1, bus.rx_tail, bus.rx_dest, bus.rx_vc, bus.rx_data};
                n_cmp++;
                if (exp_rx.size() == 0) begin
                    n_bad++; $display("FAIL rx_extra: got %h want none", got);
                end else begin
                    if (got !== exp_rx[0]) begin n_bad++; $display("FAIL rx_head: got %h want %h", got, exp_rx[0]); end
                    exp_cr.push_back('{{1'b1, exp_rx[0][DATA_W +: VC_W]}, cyc + 1});
                    void'(exp_rx.pop_front());
                end
            end else if (exp_rx.size() == 0) begin
                break;
            end
            step();
        end
        bus.rx_ready = 1'b0;
        repeat (2) step();
        n_cmp++; if (exp_rx.size() != 0)            begin n_bad++; $display("FAIL rx_missing: got %0d left want 0", exp_rx.size()); end
        n_cmp++;
        if (obs_cr.size() != exp_cr.size()) begin
            n_bad++; $display("FAIL rx_credit_count: got %0d want %0d", obs_cr.size(), exp_cr.size());
        end else begin
            foreach (exp_cr[i]) begin
                n_cmp++; if (obs_cr[i].cr !== exp_cr[i].cr) begin n_bad++; $display("FAIL rx_credit%0d: got %b want %b", i, obs_cr[i].cr, exp_cr[i].cr); end
                n_cmp++; if (obs_cr[i].c != exp_cr[i].c)    begin n_bad++; $display("FAIL rx_credit_cycle%0d: got %0d want %0d", i, obs_cr[i].c, exp_cr[i].c); end
            end
        end
        n_cmp++; if (bus.EN_putCredits !== 1'b0) begin n_bad++; $display("FAIL rx_credit_idle: got %b want 0", bus.EN_putCredits); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_tx(1'b0, 5'd7, 2'd0, 32'h77);
        bus.getFlit    = mk_flit(1'b0, 5'd2, 2'd1, 32'h99);
        bus.getCredits = {1'b1, 2'd1};
        step();
        bus.getFlit    = '0;
        bus.getCredits = '0;
        bus.rx_ready   = 1'b1;
        drive_tx(1'b1, 5'd7, 2'd0, 32'h78);
        step();
        n_cmp++; if (bus.err !== 1'b1)           begin n_bad++; $display("FAIL ar_pre_err: got %b want 1", bus.err); end
        n_cmp++; if (bus.EN_putCredits !== 1'b1) begin n_bad++; $display("FAIL ar_pre_credit: got %b want 1", bus.EN_putCredits); end
        #2 nreset = 1'b0;
        #1;
        n_cmp++; if (bus.EN_putFlit !== 1'b0)    begin n_bad++; $display("FAIL ar_en_putflit: got %b want 0", bus.EN_putFlit); end
        n_cmp++; if (bus.putFlit !== '0)         begin n_bad++; $display("FAIL ar_putflit: got %h want 0", bus.putFlit); end
        n_cmp++; if (bus.EN_putCredits !== 1'b0) begin n_bad++; $display("FAIL ar_en_putcredits: got %b want 0", bus.EN_putCredits); end
        n_cmp++; if (bus.putCredits !== '0)      begin n_bad++; $display("FAIL ar_putcredits: got %b want 0", bus.putCredits); end
        n_cmp++; if (bus.rx_valid !== 1'b0)      begin n_bad++; $display("FAIL ar_rx_valid: got %b want 0", bus.rx_valid); end
        n_cmp++; if (bus.EN_getFlit !== 1'b1)    begin n_bad++; $display("FAIL ar_en_getflit: got %b want 1", bus.EN_getFlit); end
        n_cmp++; if (bus.err !== 1'b0)           begin n_bad++; $display("FAIL ar_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.tx_ready !== 1'b1)      begin n_bad++; $display("FAIL ar_tx_ready: got %b want 1", bus.tx_ready); end
        n_cmp++; if (dut.r_credit[0] !== 5'd16)  begin n_bad++; $display("FAIL ar_credit0: got %0d want 16", dut.r_credit[0]); end
        idle_inputs();
        step();
        nreset = 1'b1;
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_packet();
        test_credit_stall();
        test_credit_edge();
        test_rx_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/noc_endpoint.md
# noc_endpoint

Parametrised credit-managed endpoint between one CONNECT network port pair (send port + receive port) and a local client (controller or processing element). Packs client flits, queues them, and injects only when the destination VC has credit. Buffers ejected flits and returns one credit per flit the client consumes. Replaces the ad-hoc credit counting in the top level and per-client flit logic, generalising to any VC count and queue depth.

## Interface
- DATA_W, 32: flit data field width (matches `FLIT_DATA_WIDTH`)
- DEST_W, 5: destination field width
- VC_W, 2: VC field width (network reserves it even when non-VC)
- NUM_VC, 1: VCs in use, 1..2^VC_W
- CREDITS, 16: initial credits per VC (network buffer depth)
- TXQ_DEPTH, 4: transmit queue entries, power of 2
- RXQ_DEPTH, 4: receive queue entries, power of 2
- FLIT_W (local): 2+DEST_W+VC_W+DATA_W; format {valid, tail, dest, vc, data}, MSB first

- sys_clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- tx_valid / tx_ready  in/out  1  client push handshake
- tx_dest  in  DEST_W  destination port
- tx_vc  in  VC_W  VC; values >= NUM_VC illegal
- tx_tail  in  1  last flit of packet
- tx_data  in  DATA_W  payload
- putFlit  out  FLIT_W  to send_ports_N_putFlit_flit_in
- EN_putFlit  out  1  inject strobe
- getCredits  in  1+VC_W  {valid, vc} from send port (EN_getCredits tied high externally)
- getFlit  in  FLIT_W  from recv_ports_N_getFlit
- EN_getFlit  out  1  drain enable
- putCredits  out  1+VC_W  {valid, vc} credit return
- EN_putCredits  out  1  credit strobe
- rx_valid / rx_ready  out/in  1  client pop handshake
- rx_dest, rx_vc, rx_tail, rx_data  out  per field  head of receive queue
- err  out  1  sticky: credit overflow or rx overrun

## Operation
- TX queue: push when tx_valid && tx_ready; tx_ready = !full.
- Credit counters: one per VC, width clog2(CREDITS+1), reset to CREDITS.
- Inject: if queue non-empty and credit[head.vc] > 0, next cycle EN_putFlit=1, putFlit={1,tail,dest,vc,data}, pop head, decrement counter. Otherwise EN_putFlit=0, putFlit=0.
- Credit return from network (getCredits valid): increment credit[vc]. Same cycle send on same VC: counter unchanged. Increment at CREDITS: counter holds, err set.
- Strict in-order injection: a blocked head blocks all VCs (no reordering; wormhole order preserved).
- EN_getFlit = !rx_full. Valid getFlit (MSB) while EN_getFlit: enqueue fields. Valid getFlit while full: flit dropped, err set.
- rx pop (rx_valid && rx_ready): next cycle EN_putCredits=1, putCredits={1, popped vc}; else both 0.
- Simultaneous push+pop on either queue at full or empty: both take effect at full (pop then push); at empty only push.
- err clears only on reset.

## Timing
- Reset: tx_ready=1 (after reset), EN_putFlit=0, putFlit=0, EN_putCredits=0, putCredits=0, rx_valid=0, EN_getFlit=1, err=0, queues empty, credits=CREDITS.
- tx push cycle N -> EN_putFlit earliest N+1 (registered outputs); sustained 1 flit/cycle with credit.
- Credit arriving cycle N is usable for the inject decision in N+1.
- getFlit valid cycle N -> rx_valid in N+1.
- Pop cycle N -> credit strobe N+1.
- Reset mid-packet: queues flushed, credits restored; partially sent packets are the system's responsibility.

## Configuration
- NOC_EP_STATS_EN defined: adds outputs tx_count, rx_count (32-bit, wrap on overflow) counting injected and ejected flits, and stall_count (32-bit) counting cycles with non-empty TX queue and zero head credit; all reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, push 2-flit packet (dest 1, vc 0, data 0xA then 0xB tail) -> EN_putFlit cycles N+1, N+2, putFlit MSB=1, tail bit 0 then 1; credit[0] 16 -> 14.
- CREDITS=2, push 4 flits vc 0, no credits returned -> 2 injected, then stall; one getCredits {1,0} -> exactly one more flit one cycle later.
- Credit return and inject same cycle same VC -> counter unchanged; extra credit at 16 -> err=1, counter stays 16.
- Inject 5 valid flits with rx_ready=0, RXQ_DEPTH=4 -> EN_getFlit low after 4; forced 5th valid flit -> err=1, queue keeps first 4.
- Pop flit with vc 1 at cycle N -> EN_putCredits=1, putCredits=3'b101 at N+1, zero at N+2.
- nreset low mid-transfer -> all outputs to reset values asynchronously, credits back to CREDITS, queues empty.
